// File: rtl/gpu_cmd_master.sv
// gpu_cmd_master: turns one box/char draw request into the GPU command-word
// write sequence, skipping coordinate/colour writes whose cached value is
// unchanged, then polls the port status until the draw completes or times out.
module gpu_cmd_master #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned POLL_LIMIT  = 1023
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [7:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [7:0]  req_xmax,
  input  logic [8:0]  req_ymax,
  input  logic [2:0]  req_color,
  input  logic [6:0]  req_char,
  output logic [31:0] bus_wdata,
  output logic        bus_oe,
  input  logic [31:0] bus_rdata,
  output logic        write,
  output logic        read,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_GAP, S_POLL, S_PGAP, S_DONE, S_TMO
  } state_t;

  localparam int unsigned   HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  localparam logic [9:0]    PLAST = 10'(POLL_LIMIT - 1);

  localparam logic [6:0] C_X     = 7'd1;
  localparam logic [6:0] C_Y     = 7'd2;
  localparam logic [6:0] C_COLOR = 7'd3;
  localparam logic [6:0] C_CHAR  = 7'd4;
  localparam logic [6:0] C_XMAX  = 7'd5;
  localparam logic [6:0] C_YMAX  = 7'd6;
  localparam logic [6:0] C_DRAW  = 7'd7;

  state_t state, state_d;

  logic [HW-1:0] hcnt;
  logic [9:0]    pcnt;
  logic [2:0]    pos;
  logic          hlast;

  logic       lat_op;
  logic [7:0] lat_x, lat_xmax;
  logic [8:0] lat_y, lat_ymax;
  logic [2:0] lat_color;
  logic [6:0] lat_char;

  logic [7:0] sh_x, sh_xmax;
  logic [8:0] sh_y, sh_ymax;
  logic [2:0] sh_color;
  logic       v_x, v_y, v_xmax, v_ymax, v_color;

  logic       cand_op;
  logic [7:0] cand_x, cand_xmax;
  logic [8:0] cand_y, cand_ymax;
  logic [2:0] cand_color;
  logic       skip_x, skip_y, skip_xmax, skip_ymax, skip_color;
  logic [2:0] start, nxt_pos;
  int unsigned seq_len;
  logic       found, ls;
  logic [6:0] lc;

  logic [6:0] cur_cmd;
  logic [8:0] payload;
  logic       is_trig;
  logic       accept;

  logic unused_rdata;
  assign unused_rdata = ^bus_rdata[31:1];

  // Command issued at each sequence position for the given request type.
  function automatic logic [6:0] seq_cmd(input logic op, input logic [2:0] p);
    if (op) begin
      case (p)
        3'd0:    return C_X;
        3'd1:    return C_Y;
        3'd2:    return C_COLOR;
        3'd3:    return C_CHAR;
        default: return 7'd0;
      endcase
    end else begin
      case (p)
        3'd0:    return C_X;
        3'd1:    return C_Y;
        3'd2:    return C_XMAX;
        3'd3:    return C_YMAX;
        3'd4:    return C_COLOR;
        3'd5:    return C_DRAW;
        default: return 7'd0;
      endcase
    end
  endfunction

  assign hlast  = (hcnt == HLAST);
  assign accept = (state == S_IDLE) && req_valid;

  // Find the next sequence position that must actually be written.
  // In IDLE the live request fields are used so the first write can start
  // on the cycle right after acceptance; skipped fields cost no cycles.
  always_comb begin
    cand_op    = lat_op;
    cand_x     = lat_x;
    cand_y     = lat_y;
    cand_xmax  = lat_xmax;
    cand_ymax  = lat_ymax;
    cand_color = lat_color;
    if (state == S_IDLE) begin
      cand_op    = req_op;
      cand_x     = req_x;
      cand_y     = req_y;
      cand_xmax  = req_xmax;
      cand_ymax  = req_ymax;
      cand_color = req_color;
    end
    skip_x     = v_x     && (sh_x     == cand_x);
    skip_y     = v_y     && (sh_y     == cand_y);
    skip_xmax  = v_xmax  && (sh_xmax  == cand_xmax);
    skip_ymax  = v_ymax  && (sh_ymax  == cand_ymax);
    skip_color = v_color && (sh_color == cand_color);
    start   = (state == S_IDLE) ? 3'd0 : pos + 3'd1;
    seq_len = cand_op ? 32'd4 : 32'd6;
    nxt_pos = '0;
    found   = 1'b0;
    lc      = '0;
    ls      = 1'b0;
    for (int unsigned p = 0; p < 6; p++) begin
      if (!found && (p >= 32'(start)) && (p < seq_len)) begin
        lc = seq_cmd(cand_op, 3'(p));
        case (lc)
          C_X:     ls = skip_x;
          C_Y:     ls = skip_y;
          C_XMAX:  ls = skip_xmax;
          C_YMAX:  ls = skip_ymax;
          C_COLOR: ls = skip_color;
          default: ls = 1'b0;
        endcase
        if (!ls) begin
          found   = 1'b1;
          nxt_pos = 3'(p);
        end
      end
    end
  end

  // Current command word, driven onto the bus only while writing.
  always_comb begin
    cur_cmd = seq_cmd(lat_op, pos);
    is_trig = (cur_cmd == C_DRAW) || (cur_cmd == C_CHAR);
    case (cur_cmd)
      C_X:     payload = {1'b0, lat_x};
      C_Y:     payload = lat_y;
      C_COLOR: payload = {6'b0, lat_color};
      C_CHAR:  payload = {2'b0, lat_char};
      C_XMAX:  payload = {1'b0, lat_xmax};
      C_YMAX:  payload = lat_ymax;
      default: payload = '0;
    endcase
    bus_wdata = (state == S_WRITE) ? {16'h0, cur_cmd, payload} : '0;
  end

  // State register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    write     = 1'b0;
    bus_oe    = 1'b0;
    read      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        write  = 1'b1;
        bus_oe = 1'b1;
        if (hlast) state_d = S_GAP;
      end
      S_GAP:   state_d = is_trig ? S_POLL : S_WRITE;
      S_POLL: begin
        read = 1'b1;
        if (hlast) begin
          if (!bus_rdata[0])      state_d = S_DONE;
          else if (pcnt == PLAST) state_d = S_TMO;
          else                    state_d = S_PGAP;
        end
      end
      S_PGAP:  state_d = S_POLL;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_TMO: begin
        timeout = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, hold/poll counters, sequence position and shadow cache.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      hcnt      <= '0;
      pcnt      <= '0;
      pos       <= '0;
      lat_op    <= 1'b0;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_xmax  <= '0;
      lat_ymax  <= '0;
      lat_color <= '0;
      lat_char  <= '0;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_xmax   <= '0;
      sh_ymax   <= '0;
      sh_color  <= '0;
      v_x       <= 1'b0;
      v_y       <= 1'b0;
      v_xmax    <= 1'b0;
      v_ymax    <= 1'b0;
      v_color   <= 1'b0;
    end else begin
      if (((state == S_WRITE) || (state == S_POLL)) && !hlast) hcnt <= hcnt + 1'b1;
      else                                                     hcnt <= '0;

      if (accept) begin
        lat_op    <= req_op;
        lat_x     <= req_x;
        lat_y     <= req_y;
        lat_xmax  <= req_xmax;
        lat_ymax  <= req_ymax;
        lat_color <= req_color;
        lat_char  <= req_char;
        pos       <= nxt_pos;
        pcnt      <= '0;
      end

      if ((state == S_GAP) && !is_trig) pos <= nxt_pos;

      if ((state == S_POLL) && hlast) pcnt <= pcnt + 1'b1;

      if ((state == S_WRITE) && hlast) begin
        case (cur_cmd)
          C_X:     begin sh_x     <= lat_x;     v_x     <= 1'b1; end
          C_Y:     begin sh_y     <= lat_y;     v_y     <= 1'b1; end
          C_XMAX:  begin sh_xmax  <= lat_xmax;  v_xmax  <= 1'b1; end
          C_YMAX:  begin sh_ymax  <= lat_ymax;  v_ymax  <= 1'b1; end
          C_COLOR: begin sh_color <= lat_color; v_color <= 1'b1; end
          default: ;
        endcase
      end

      if (state == S_TMO) begin
        v_x     <= 1'b0;
        v_y     <= 1'b0;
        v_xmax  <= 1'b0;
        v_ymax  <= 1'b0;
        v_color <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gpu_cmd_master.md
# gpu_cmd_master

Bus initiator that turns a single draw request (box or character) into the 7-bit command-word write sequence accepted by the VGA/GPU command port. It then polls the port's status word until the draw completes. It sits between a fabric-side requester (sprite engine, text console) and the shared 32-bit VGA data bus, replacing hand-coded CPU write loops. It suppresses rewrites of coordinate/colour registers whose value is unchanged since the last request.

## Interface
- HOLD_CYCLES, 2: clk50 cycles each read/write strobe is held (≥1); covers the slower port-sampling clock.
- POLL_LIMIT, 1023: max status polls per request before timeout.
- clk50  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  draw request present.
- req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready.
- req_op  in  1  0 = box, 1 = character.
- req_x  in  8  x origin.
- req_y  in  9  y origin.
- req_xmax  in  8  box x end (ignored for char).
- req_ymax  in  9  box y end (ignored for char).
- req_color  in  3  RGB colour.
- req_char  in  7  character code (ignored for box).
- bus_wdata  out  32  command word; top level drives the shared bus with it when bus_oe=1.
- bus_oe  out  1  high exactly while write=1.
- bus_rdata  in  32  bus value; only bit 0 used, 1 = port busy.
- write  out  1  command write strobe.
- read  out  1  status read strobe.
- done  out  1  one-cycle pulse when a request completes.
- timeout  out  1  one-cycle pulse when POLL_LIMIT is exhausted.

## Operation
- Command word: bits[31:16]=0, [15:9]=command, [8:0]=zero-extended payload.
  - X=1 (x[7:0]), Y=2 (y[8:0]), COLOR=3 (color[2:0]), CHAR=4 (char[6:0]), XMAX=5, YMAX=6, DRAWBOX=7 (payload 0).
- On accept, all req_* fields are latched; inputs are ignored afterwards.
- Box sequence: X, Y, XMAX, YMAX, COLOR, DRAWBOX.
- Char sequence: X, Y, COLOR, CHAR. CHAR is the trigger.
- Shadow cache: last-written X, Y, XMAX, YMAX, COLOR values, each with a valid bit.
  - A non-trigger field is skipped if its valid bit is set and its value matches.
  - Trigger commands are never skipped.
  - Shadow and valid bits update at the end of each write.
- States: IDLE → WRITE → GAP → (next field: WRITE | after trigger: POLL) → PGAP → POLL … → DONE → IDLE.
  - WRITE: write=1, bus_oe=1, bus_wdata valid, for HOLD_CYCLES cycles.
  - GAP: 1 cycle, all strobes 0.
  - POLL: read=1 for HOLD_CYCLES cycles; bus_rdata[0] is sampled on the last cycle.
    - Sampled 1: enter PGAP (1 cycle), then POLL again.
    - Sampled 0: enter DONE.
  - DONE: done=1 for 1 cycle, then IDLE.
- Timeout: after POLL_LIMIT polls that all sampled 1, pulse timeout (not done) for 1 cycle.
  - All valid bits clear and the block returns to IDLE.
- Reset (async, any state): state=IDLE, all valid bits=0, counters=0.
  - Outputs after reset: req_ready=1, write=read=bus_oe=done=timeout=0, bus_wdata=0.
  - A sequence interrupted by reset is abandoned; nothing is replayed.
- write and read are never high in the same cycle; bus_wdata=0 whenever bus_oe=0.

## Timing
- Accept at edge N; first WRITE cycle is N+1.
- Each issued write occupies HOLD_CYCLES+1 cycles (WRITE plus GAP).
  - Box, cold cache, H=2: writes span N+1..N+18; first POLL at N+19.
- Each poll occupies HOLD_CYCLES+1 cycles (POLL plus PGAP).
- Immediate not-busy: DONE at N+19+H, i.e. N+21 for H=2. req_ready rises the cycle after DONE.
- Fully cached char, H=2: only CHAR is written (N+1..N+3); first POLL at N+4.
- Poll count is ≤ POLL_LIMIT; the count is 10 bits wide, so POLL_LIMIT ≤ 1023.

## Test plan
- Box, cold cache (x=10, y=300, xmax=50, ymax=400, color=5), port never busy, H=2.
  - Expect write words 0x020A, 0x052C, 0x0A32, 0x0D90, 0x0605, 0x0E00 in order.
  - Expect one read, then done at N+21.
- Repeat the same box.
  - Expect only 0x0E00 written; done at N+6.
- Char 'A' (0x41) at x=10, y=300, color=5 after the box.
  - Expect only 0x0841 written.
  - Change color to 2: expect 0x0602 then 0x0841.
- Busy status holds bus_rdata[0]=1 for 4 polls, then 0.
  - Expect exactly 5 read bursts separated by 1-cycle gaps, then a single done pulse.
- POLL_LIMIT=3 with bus_rdata[0] stuck at 1.
  - Expect 3 polls, a timeout pulse, and no done.
  - Next identical request rewrites all fields (cache invalidated).
- Assert reset mid-WRITE of YMAX.
  - Outputs immediately return to reset values.
  - Next request rewrites X, Y, XMAX, YMAX, COLOR, DRAWBOX in full.
